// File: rtl/tt_sweep_ctrl_if.sv
// Control/result bundle between a test master and the truth-table sweep sequencer.
// The slave side is the sequencer; the master both controls the sweep and models the expressions.
interface tt_sweep_ctrl_if #(
    parameter int unsigned N_IN = 2
) ();
    localparam int unsigned NVec = 1 << N_IN;

    logic              start;
    logic              abort;
    logic              sa;
    logic              sb;
    logic [N_IN-1:0]   vec_out;
    logic              busy;
    logic              done;
    logic              equal;
    logic [N_IN:0]     mismatch_cnt;
    logic [N_IN-1:0]   first_fail;
    logic              first_fail_vld;
    logic [NVec-1:0]   tt_a;
    logic [NVec-1:0]   tt_b;

    modport slave (
        input  start, abort, sa, sb,
        output vec_out, busy, done, equal, mismatch_cnt, first_fail, first_fail_vld, tt_a, tt_b
    );

    modport master (
        output start, abort, sa, sb,
        input  vec_out, busy, done, equal, mismatch_cnt, first_fail, first_fail_vld, tt_a, tt_b
    );
endinterface

// File: rtl/tt_sweep_ctrl.sv
// Sweeps all 2^N_IN input vectors, holds each SETTLE cycles, samples two expression outputs,
// and records both truth tables, the mismatch count, the first failing vector and equivalence.
module tt_sweep_ctrl #(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    tt_sweep_ctrl_if.slave   bus
);
    localparam int unsigned NVec     = 1 << N_IN;
    localparam bit          NoSettle = (SETTLE == 0);
    localparam logic [3:0]  WaitLoad = NoSettle ? 4'd0 : 4'(SETTLE - 1);
    localparam logic [3:0]  WaitOne  = 4'd1;
    localparam logic [N_IN:0]   MmOne  = (N_IN + 1)'(1);
    localparam logic [N_IN-1:0] VecOne = N_IN'(1);

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

    state_e          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [3:0]      wait_q, wait_d;
    logic [N_IN:0]   mm_q, mm_d;
    logic [N_IN-1:0] ff_q, ff_d;
    logic            ffv_q, ffv_d;
    logic [NVec-1:0] tta_q, tta_d;
    logic [NVec-1:0] ttb_q, ttb_d;
    logic            eq_q, eq_d;

    logic last_vec;
    logic miss;

    assign last_vec = (vec_q == {N_IN{1'b1}});
    assign miss     = (bus.sa != bus.sb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // abort outranks every transition, including start in IDLE
    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start) state_d = NoSettle ? StSample : StSettle;
                end
                StSettle: begin
                    if (wait_q == '0) state_d = StSample;
                end
                StSample: begin
                    if (last_vec) state_d = StDone;
                    else          state_d = NoSettle ? StSample : StSettle;
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        vec_d  = vec_q;
        wait_d = wait_q;
        mm_d   = mm_q;
        ff_d   = ff_q;
        ffv_d  = ffv_q;
        tta_d  = tta_q;
        ttb_d  = ttb_q;
        eq_d   = eq_q;
        if (bus.abort) begin
            // partial truth tables and counts are left visible
            vec_d  = '0;
            wait_d = '0;
            eq_d   = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        vec_d  = '0;
                        wait_d = WaitLoad;
                        mm_d   = '0;
                        ff_d   = '0;
                        ffv_d  = 1'b0;
                        tta_d  = '0;
                        ttb_d  = '0;
                        eq_d   = 1'b0;
                    end
                end
                StSettle: begin
                    if (wait_q != '0) wait_d = wait_q - WaitOne;
                end
                StSample: begin
                    tta_d[vec_q] = bus.sa;
                    ttb_d[vec_q] = bus.sb;
                    if (miss) begin
                        mm_d = mm_q + MmOne;
                        if (!ffv_q) begin
                            ff_d  = vec_q;
                            ffv_d = 1'b1;
                        end
                    end
                    if (last_vec) begin
                        vec_d = '0;
                        eq_d  = (mm_d == '0);
                    end else begin
                        vec_d  = vec_q + VecOne;
                        wait_d = WaitLoad;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q  <= '0;
            wait_q <= '0;
            mm_q   <= '0;
            ff_q   <= '0;
            ffv_q  <= 1'b0;
            tta_q  <= '0;
            ttb_q  <= '0;
            eq_q   <= 1'b0;
        end else begin
            vec_q  <= vec_d;
            wait_q <= wait_d;
            mm_q   <= mm_d;
            ff_q   <= ff_d;
            ffv_q  <= ffv_d;
            tta_q  <= tta_d;
            ttb_q  <= ttb_d;
            eq_q   <= eq_d;
        end
    end

    // busy/done are pure decodes of the state register, so they stay glitch-free
    always_comb begin
        bus.busy           = (state_q == StSettle) || (state_q == StSample);
        bus.done           = (state_q == StDone);
        bus.vec_out        = vec_q;
        bus.equal          = eq_q;
        bus.mismatch_cnt   = mm_q;
        bus.first_fail     = ff_q;
        bus.first_fail_vld = ffv_q;
        bus.tt_a           = tta_q;
        bus.tt_b           = ttb_q;
    end
endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: table-driven sweeps scored at done, plus restart, abort and
// reset sequences; a second instance covers the zero-settle case.
module tb_tt_sweep_ctrl;
    typedef struct {
        int         sel_a;
        int         sel_b;
        logic [3:0] tta;
        logic [3:0] ttb;
        logic [2:0] mm;
        logic [1:0] ff;
        logic       ffv;
        logic       eq;
    } vec_t;

    logic clk;
    logic rst_n;
    logic start1, abort1, start0, abort0;
    int   sel_a1, sel_b1, sel_a0, sel_b0;
    int   checks;
    int   errors;
    vec_t sb_q[$];
    vec_t tbl[6];
    vec_t cur;

    tt_sweep_ctrl_if #(.N_IN(2)) if1 ();
    tt_sweep_ctrl_if #(.N_IN(2)) if0 ();

    tt_sweep_ctrl #(.N_IN(2), .SETTLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    tt_sweep_ctrl #(.N_IN(2), .SETTLE(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));

    // x = v[1], y = v[0]
    function automatic logic expr(input int sel, input logic [1:0] v);
        logic x, y;
        x = v[1];
        y = v[0];
        case (sel)
            0:       return x & y;
            1:       return (~(~y | ~x)) & (y | ~x);
            2:       return x | y;
            3:       return ~x;
            4:       return x ^ y;
            6:       return x;
            default: return 1'b0;
        endcase
    endfunction

    assign if1.start = start1;
    assign if1.abort = abort1;
    assign if1.sa    = expr(sel_a1, if1.vec_out);
    assign if1.sb    = expr(sel_b1, if1.vec_out);
    assign if0.start = start0;
    assign if0.abort = abort0;
    assign if0.sa    = expr(sel_a0, if0.vec_out);
    assign if0.sb    = expr(sel_b0, if0.vec_out);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard: every done on the SETTLE=1 instance must match a queued expectation
    always @(negedge clk) begin
        if (rst_n && if1.done) begin
            check("sb_pending", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                cur = sb_q.pop_front();
                check("tt_a", 32'(if1.tt_a), 32'(cur.tta));
                check("tt_b", 32'(if1.tt_b), 32'(cur.ttb));
                check("mismatch_cnt", 32'(if1.mismatch_cnt), 32'(cur.mm));
                check("first_fail", 32'(if1.first_fail), 32'(cur.ff));
                check("first_fail_vld", 32'(if1.first_fail_vld), 32'(cur.ffv));
                check("equal_at_done", 32'(if1.equal), 32'(cur.eq));
            end
        end
    end

    task automatic pulse_start1();
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic run_sweep(input vec_t e, input int poke_vec);
        int n;
        bit poked;
        sel_a1 = e.sel_a;
        sel_b1 = e.sel_b;
        sb_q.push_back(e);
        pulse_start1();
        n = 0;
        poked = 0;
        while (if1.busy && n < 100) begin
            if (!poked && int'(if1.vec_out) == poke_vec) begin
                start1 = 1'b1;
                poked = 1;
            end else begin
                start1 = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        start1 = 1'b0;
        check("busy_cycles", 32'(n), 32'd8);
        check("done_after_busy", 32'(if1.done), 32'd1);
        @(negedge clk);
        check("done_one_cycle", 32'(if1.done), 32'd0);
        check("equal_holds", 32'(if1.equal), 32'(e.eq));
        @(negedge clk);
        check("idle_after_done", 32'(if1.busy), 32'd0);
    endtask

    task automatic wait_vec1(input logic [1:0] v, output bit ok);
        int n;
        n = 0;
        while (!(if1.busy && if1.vec_out == v) && n < 50) begin
            n++;
            @(negedge clk);
        end
        ok = (n < 50);
    endtask

    initial begin
        int  n;
        bit  ok;
        int  rec[4];
        checks = 0;
        errors = 0;
        start1 = 0; abort1 = 0; start0 = 0; abort0 = 0;
        sel_a1 = 0; sel_b1 = 0; sel_a0 = 0; sel_b0 = 0;
        //         sel_a sel_b tta     ttb     mm    ff     ffv eq
        tbl[0] = '{0, 1, 4'b1000, 4'b1000, 3'd0, 2'b00, 0, 1};
        tbl[1] = '{0, 2, 4'b1000, 4'b1110, 3'd2, 2'b01, 1, 0};
        tbl[2] = '{3, 3, 4'b0011, 4'b0011, 3'd0, 2'b00, 0, 1};
        tbl[3] = '{4, 2, 4'b0110, 4'b1110, 3'd1, 2'b11, 1, 0};
        tbl[4] = '{3, 2, 4'b0011, 4'b1110, 3'd3, 2'b00, 1, 0};
        tbl[5] = '{3, 6, 4'b0011, 4'b1100, 3'd4, 2'b00, 1, 0};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(if1.busy), 32'd0);
        check("rst_done", 32'(if1.done), 32'd0);
        check("rst_outputs", 32'({if1.tt_a, if1.tt_b, if1.mismatch_cnt, if1.first_fail,
                                  if1.first_fail_vld, if1.equal, if1.vec_out}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_rst", 32'(if1.busy), 32'd0);

        for (int i = 0; i < 6; i++) run_sweep(tbl[i], -1);

        // start pulsed again mid-sweep: must be ignored
        run_sweep(tbl[1], 2);
        repeat (10) @(negedge clk);
        check("no_queued_sweep", 32'(if1.busy), 32'd0);

        // abort during vector 1 of a mismatching sweep
        sel_a1 = 0;
        sel_b1 = 2;
        pulse_start1();
        wait_vec1(2'd1, ok);
        check("abort_reach_vec1", 32'(ok), 32'd1);
        @(negedge clk);
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        check("abort_busy", 32'(if1.busy), 32'd0);
        check("abort_done", 32'(if1.done), 32'd0);
        check("abort_equal", 32'(if1.equal), 32'd0);
        check("abort_vec", 32'(if1.vec_out), 32'd0);
        check("abort_partial_tta", 32'(if1.tt_a), 32'd0);
        check("abort_partial_mm", 32'(if1.mismatch_cnt), 32'd0);
        repeat (12) @(negedge clk);
        check("abort_still_idle", 32'(if1.busy), 32'd0);
        run_sweep(tbl[1], -1);

        // abort and start together in IDLE: no sweep
        start1 = 1'b1;
        abort1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        abort1 = 1'b0;
        check("abort_beats_start", 32'(if1.busy), 32'd0);
        repeat (3) @(negedge clk);
        check("abort_beats_start_later", 32'(if1.busy), 32'd0);

        // reset mid-sweep after one mismatch has been counted
        sel_a1 = 0;
        sel_b1 = 2;
        pulse_start1();
        wait_vec1(2'd2, ok);
        check("rst_reach_vec2", 32'(ok), 32'd1);
        check("rst_pre_mm", 32'(if1.mismatch_cnt), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_busy", 32'(if1.busy), 32'd0);
        check("rst_async_mm", 32'(if1.mismatch_cnt), 32'd0);
        check("rst_async_ttb", 32'(if1.tt_b), 32'd0);
        check("rst_async_vec", 32'(if1.vec_out), 32'd0);
        check("rst_async_ffv", 32'(if1.first_fail_vld), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("rst_stays_idle", 32'(if1.busy), 32'd0);
        check("rst_no_done", 32'(if1.done), 32'd0);

        // zero-settle instance: each vector held exactly one cycle
        sel_a0 = 3;
        sel_b0 = 3;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        n = 0;
        while (if0.busy && n < 20) begin
            if (n < 4) rec[n] = int'(if0.vec_out);
            n++;
            @(negedge clk);
        end
        check("s0_busy_cycles", 32'(n), 32'd4);
        for (int i = 0; i < 4; i++) check("s0_vec_seq", 32'(rec[i]), 32'(i));
        check("s0_done", 32'(if0.done), 32'd1);
        check("s0_tt_a", 32'(if0.tt_a), 32'b0011);
        check("s0_tt_b", 32'(if0.tt_b), 32'b0011);
        check("s0_equal", 32'(if0.equal), 32'd1);
        check("s0_mm", 32'(if0.mismatch_cnt), 32'd0);
        @(negedge clk);
        check("s0_done_pulse", 32'(if0.done), 32'd0);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
